// File: rtl/vital_pkg.sv
// ---------------------------------------------------------------------------
// vital_pkg
// Shared definitions for the vital-sign alarm monitor.
//   state_e     : monitor FSM state (NORMAL/PENDING/ALARM/RECOVERING), 2 bits
//   EVENT_MAX   : saturation value of the alarm-entry counter
//   count_width : bits needed to hold a confirm/clear count up to max_count
//   CNT_W       : width of the confirm/clear counters (counts are 1..15)
// ---------------------------------------------------------------------------
package vital_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL     = 2'd0,
        ST_PENDING    = 2'd1,
        ST_ALARM      = 2'd2,
        ST_RECOVERING = 2'd3
    } state_e;

    localparam int EVENT_MAX = 255;

    function automatic int count_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

    localparam int CNT_W = count_width(15);

endpackage

// File: rtl/alarm_blinker.sv
// ---------------------------------------------------------------------------
// alarm_blinker
// Buzzer half-period generator. The buzzer phase starts high on restart and
// toggles every BLINK_HALF enabled cycles. Inputs are the *next-cycle* values
// from the monitor so the buzzer register lines up with the other outputs.
//   clock     : system clock, rising edge
//   resetN    : asynchronous active-low reset
//   i_enable  : alarm will be active next cycle; 0 clears the blink state
//   i_mute    : buzzer silenced next cycle (blinking keeps its phase)
//   i_restart : alarm is being freshly entered; phase restarts high
//   o_buzzer  : registered blink output
// ---------------------------------------------------------------------------
module alarm_blinker #(
    parameter int BLINK_HALF = 8
) (
    input  logic clock,
    input  logic resetN,
    input  logic i_enable,
    input  logic i_mute,
    input  logic i_restart,
    output logic o_buzzer
);

    localparam int HW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [HW-1:0] r_cnt;
    logic [HW-1:0] w_cnt_next;
    logic          r_phase;
    logic          w_phase_next;
    logic          r_buzzer;

    always_comb begin
        w_cnt_next   = r_cnt;
        w_phase_next = r_phase;
        if (!i_enable) begin
            w_cnt_next   = '0;
            w_phase_next = 1'b0;
        end else if (i_restart) begin
            w_cnt_next   = '0;
            w_phase_next = 1'b1;
        end else if (r_cnt == HW'(BLINK_HALF - 1)) begin
            w_cnt_next   = '0;
            w_phase_next = ~r_phase;
        end else begin
            w_cnt_next   = r_cnt + HW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            r_buzzer <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_phase  <= w_phase_next;
            r_buzzer <= w_phase_next & i_enable & ~i_mute;
        end
    end

    assign o_buzzer = r_buzzer;

endmodule

// File: rtl/vital_alarm_monitor.sv
// ---------------------------------------------------------------------------
// vital_alarm_monitor
// Confirms out-of-range vital-sign readings over consecutive samples, latches
// an alarm with its cause, blinks a buzzer until acknowledged and requires
// consecutive in-range samples before clearing.
//   clock/resetN            : clock (rising edge), async active-low reset
//   sampleValid             : comparator results valid this cycle
//   belowLow / aboveHigh    : low-limit / high-limit comparator results
//   alarmEnable             : level, 0 forces the monitor idle
//   alarmAck                : one-cycle acknowledge, mutes the buzzer
//   alarmActive             : ALARM or RECOVERING
//   causeLow / causeHigh    : latched causes, visible only while alarmActive
//   buzzer                  : blink output
//   monitorState            : FSM state encoding
//   alarmEvents             : saturating count of fresh ALARM entries
// ---------------------------------------------------------------------------
module vital_alarm_monitor
    import vital_pkg::*;
#(
    parameter int CONFIRM_COUNT = 4,
    parameter int CLEAR_COUNT   = 4,
    parameter int BLINK_HALF    = 8
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       sampleValid,
    input  logic       belowLow,
    input  logic       aboveHigh,
    input  logic       alarmEnable,
    input  logic       alarmAck,
    output logic       alarmActive,
    output logic       causeLow,
    output logic       causeHigh,
    output logic       buzzer,
    output logic [1:0] monitorState,
    output logic [7:0] alarmEvents
);

    state_e           r_state, w_state_next;
    logic [CNT_W-1:0] r_confirm, w_confirm_next;
    logic [CNT_W-1:0] r_clear, w_clear_next;
    logic             r_cause_low, w_cause_low_next;
    logic             r_cause_high, w_cause_high_next;
    logic             r_mute, w_mute_next;
    logic [7:0]       r_events, w_events_next;
    logic             r_active, r_cause_low_out, r_cause_high_out;
    logic             w_enter_alarm;
    logic             w_active, w_active_next;

    // Sample qualification: comparator levels only count on a strobe.
    logic w_smp_low, w_smp_high, w_oor, w_in_range;
    assign w_smp_low  = sampleValid & belowLow;
    assign w_smp_high = sampleValid & aboveHigh;
    assign w_oor      = w_smp_low | w_smp_high;
    assign w_in_range = sampleValid & ~w_oor;
    assign w_active   = (r_state == ST_ALARM) || (r_state == ST_RECOVERING);

    // Next-state and counter logic.
    always_comb begin
        w_state_next      = r_state;
        w_confirm_next    = r_confirm;
        w_clear_next      = r_clear;
        w_cause_low_next  = r_cause_low;
        w_cause_high_next = r_cause_high;
        w_enter_alarm     = 1'b0;
        if (!alarmEnable) begin
            w_state_next      = ST_NORMAL;
            w_confirm_next    = '0;
            w_clear_next      = '0;
            w_cause_low_next  = 1'b0;
            w_cause_high_next = 1'b0;
        end else begin
            // Causes accumulate on every oor sample; cleared below on exit.
            if (w_oor) begin
                w_cause_low_next  = r_cause_low | w_smp_low;
                w_cause_high_next = r_cause_high | w_smp_high;
            end
            unique case (r_state)
                ST_NORMAL: begin
                    if (w_oor) begin
                        if (CONFIRM_COUNT == 1) begin
                            w_state_next  = ST_ALARM;
                            w_enter_alarm = 1'b1;
                        end else begin
                            w_state_next   = ST_PENDING;
                            w_confirm_next = CNT_W'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (w_oor) begin
                        if (r_confirm + CNT_W'(1) == CNT_W'(CONFIRM_COUNT)) begin
                            w_state_next   = ST_ALARM;
                            w_confirm_next = '0;
                            w_enter_alarm  = 1'b1;
                        end else begin
                            w_confirm_next = r_confirm + CNT_W'(1);
                        end
                    end else if (w_in_range) begin
                        w_state_next      = ST_NORMAL;
                        w_confirm_next    = '0;
                        w_cause_low_next  = 1'b0;
                        w_cause_high_next = 1'b0;
                    end
                end
                ST_ALARM: begin
                    if (w_in_range) begin
                        if (CLEAR_COUNT == 1) begin
                            w_state_next      = ST_NORMAL;
                            w_cause_low_next  = 1'b0;
                            w_cause_high_next = 1'b0;
                        end else begin
                            w_state_next = ST_RECOVERING;
                            w_clear_next = CNT_W'(1);
                        end
                    end
                end
                ST_RECOVERING: begin
                    if (w_oor) begin
                        w_state_next = ST_ALARM;
                        w_clear_next = '0;
                    end else if (w_in_range) begin
                        if (r_clear + CNT_W'(1) == CNT_W'(CLEAR_COUNT)) begin
                            w_state_next      = ST_NORMAL;
                            w_clear_next      = '0;
                            w_cause_low_next  = 1'b0;
                            w_cause_high_next = 1'b0;
                        end else begin
                            w_clear_next = r_clear + CNT_W'(1);
                        end
                    end
                end
                default: w_state_next = ST_NORMAL;
            endcase
        end
    end

    // Output-side next values: mute, event counter, alarm-active.
    always_comb begin
        w_active_next = (w_state_next == ST_ALARM) || (w_state_next == ST_RECOVERING);
        // Mute survives RECOVERING<->ALARM bounces; it only clears when the
        // alarm fully ends (or is disabled).
        if (!w_active_next) begin
            w_mute_next = 1'b0;
        end else begin
            w_mute_next = r_mute | (alarmAck & w_active);
        end
        w_events_next = r_events;
        if (w_enter_alarm && (r_events != 8'(EVENT_MAX))) begin
            w_events_next = r_events + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state          <= ST_NORMAL;
            r_confirm        <= '0;
            r_clear          <= '0;
            r_cause_low      <= 1'b0;
            r_cause_high     <= 1'b0;
            r_mute           <= 1'b0;
            r_events         <= '0;
            r_active         <= 1'b0;
            r_cause_low_out  <= 1'b0;
            r_cause_high_out <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_confirm        <= w_confirm_next;
            r_clear          <= w_clear_next;
            r_cause_low      <= w_cause_low_next;
            r_cause_high     <= w_cause_high_next;
            r_mute           <= w_mute_next;
            r_events         <= w_events_next;
            r_active         <= w_active_next;
            r_cause_low_out  <= w_cause_low_next & w_active_next;
            r_cause_high_out <= w_cause_high_next & w_active_next;
        end
    end

    alarm_blinker #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blinker (
        .clock     (clock),
        .resetN    (resetN),
        .i_enable  (w_active_next),
        .i_mute    (w_mute_next),
        .i_restart (w_enter_alarm),
        .o_buzzer  (buzzer)
    );

    assign alarmActive  = r_active;
    assign causeLow     = r_cause_low_out;
    assign causeHigh    = r_cause_high_out;
    assign monitorState = r_state;
    assign alarmEvents  = r_events;

endmodule

// File: tb/tb_vital_alarm_monitor.sv
// ---------------------------------------------------------------------------
// tb_vital_alarm_monitor
// Scoreboard bench: the driver applies one cycle of inputs at each falling
// edge, advances a run-length based reference model and queues the expected
// outputs; the monitor pops and compares just after each rising edge.
// ---------------------------------------------------------------------------
module tb_vital_alarm_monitor;

    localparam int CONFIRM = 4;
    localparam int CLEAR   = 4;
    localparam int BH      = 8;

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       sampleValid = 1'b0, belowLow = 1'b0, aboveHigh = 1'b0;
    logic       alarmEnable = 1'b1, alarmAck = 1'b0;
    logic       alarmActive, causeLow, causeHigh, buzzer;
    logic [1:0] monitorState;
    logic [7:0] alarmEvents;

    vital_alarm_monitor #(
        .CONFIRM_COUNT (CONFIRM),
        .CLEAR_COUNT   (CLEAR),
        .BLINK_HALF    (BH)
    ) dut (
        .clock        (clock),
        .resetN       (resetN),
        .sampleValid  (sampleValid),
        .belowLow     (belowLow),
        .aboveHigh    (aboveHigh),
        .alarmEnable  (alarmEnable),
        .alarmAck     (alarmAck),
        .alarmActive  (alarmActive),
        .causeLow     (causeLow),
        .causeHigh    (causeHigh),
        .buzzer       (buzzer),
        .monitorState (monitorState),
        .alarmEvents  (alarmEvents)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [13:0] outs;   // {state, active, causeLow, causeHigh, buzzer, events}
        bit          txn;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: alarm flag plus run lengths of oor / in-range samples.
    bit m_alarm, m_cl, m_ch, m_mute;
    int m_oor_run, m_ok_run, m_age, m_events;

    function automatic logic [13:0] dut_outs();
        return {monitorState, alarmActive, causeLow, causeHigh, buzzer, alarmEvents};
    endfunction

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got st=%0d act=%b cl=%b ch=%b bz=%b ev=%0d want st=%0d act=%b cl=%b ch=%b bz=%b ev=%0d",
                     name, got[13:12], got[11], got[10], got[9], got[8], got[7:0],
                     want[13:12], want[11], want[10], want[9], want[8], want[7:0]);
        end
    endtask

    task automatic model_reset();
        m_alarm = 0; m_cl = 0; m_ch = 0; m_mute = 0;
        m_oor_run = 0; m_ok_run = 0; m_age = 0; m_events = 0;
    endtask

    function automatic logic [13:0] model_outs();
        int st;
        bit bz;
        if (!m_alarm) st = (m_oor_run > 0) ? 1 : 0;
        else          st = (m_ok_run > 0) ? 3 : 2;
        bz = m_alarm && !m_mute && (((m_age / BH) % 2) == 0);
        return {2'(st), m_alarm, m_cl & m_alarm, m_ch & m_alarm, bz, 8'(m_events)};
    endfunction

    task automatic model_step(input bit sv, input bit bl, input bit ah, input bit en, input bit ack);
        bit was_alarm;
        bit ack_hit;
        was_alarm = m_alarm;
        ack_hit   = ack && was_alarm;
        if (!en) begin
            m_alarm = 0; m_cl = 0; m_ch = 0; m_mute = 0;
            m_oor_run = 0; m_ok_run = 0;
        end else begin
            if (sv && (bl || ah)) begin
                m_oor_run++;
                m_ok_run = 0;
                m_cl = m_cl | bl;
                m_ch = m_ch | ah;
                if (!m_alarm && m_oor_run >= CONFIRM) begin
                    m_alarm  = 1;
                    m_events = (m_events < 255) ? m_events + 1 : 255;
                end
            end else if (sv) begin
                m_oor_run = 0;
                if (!m_alarm) begin
                    m_cl = 0; m_ch = 0;
                end else begin
                    m_ok_run++;
                    if (m_ok_run >= CLEAR) begin
                        m_alarm = 0; m_ok_run = 0; m_cl = 0; m_ch = 0; m_mute = 0;
                    end
                end
            end
            if (m_alarm) m_mute = m_mute | ack_hit;
        end
        // Age counts cycles since a fresh alarm began; bounces through
        // RECOVERING keep the alarm (and its blink timing) alive.
        if (m_alarm) m_age = was_alarm ? m_age + 1 : 0;
    endtask

    task automatic do_cycle(input bit sv, input bit bl, input bit ah, input bit en, input bit ack);
        exp_t e;
        @(negedge clock);
        sampleValid = sv; belowLow = bl; aboveHigh = ah; alarmEnable = en; alarmAck = ack;
        model_step(sv, bl, ah, en, ack);
        e.outs = model_outs();
        e.txn  = sv || ack || !en;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 1, 0);
    endtask

    task automatic samples(input int n, input bit bl, input bit ah);
        for (int i = 0; i < n; i++) do_cycle(1, bl, ah, 1, 0);
    endtask

    // Monitor: compare the queued expectation after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("cycle", dut_outs(), e.outs);
                if (e.txn)
                    $display("txn t=%0t st=%0d act=%b cl=%b ch=%b bz=%b ev=%0d",
                             $time, monitorState, alarmActive, causeLow, causeHigh, buzzer, alarmEvents);
            end
        end
    end

    initial begin
        model_reset();
        #12;
        check("reset_hold", dut_outs(), 14'd0);
        @(negedge clock);
        resetN = 1'b1;
        idle(2);

        // 1. Asynchronous reset in the middle of an alarm.
        samples(4, 0, 1);
        idle(3);
        @(negedge clock);
        #2 resetN = 1'b0;
        #1 check("async_reset", dut_outs(), 14'd0);
        model_reset();
        @(negedge clock);
        resetN = 1'b1;
        idle(2);

        // 2. Three low samples then in-range: no alarm. Then confirm on four.
        samples(3, 1, 0);
        samples(1, 0, 0);
        samples(4, 1, 0);
        idle(2 * BH + 4);

        // Clear back to NORMAL.
        samples(4, 0, 0);
        idle(2);

        // 3. Mixed cause over alternating directions.
        do_cycle(1, 1, 0, 1, 0);
        do_cycle(1, 0, 1, 1, 0);
        do_cycle(1, 1, 0, 1, 0);
        do_cycle(1, 0, 1, 1, 0);
        idle(3);

        // 4. Ack, partial recovery, re-alarm, full recovery.
        do_cycle(0, 0, 0, 1, 1);
        idle(2);
        samples(3, 0, 0);
        samples(1, 1, 0);
        idle(2);
        samples(4, 0, 0);
        idle(2);
        // Ack while NORMAL or PENDING has no effect.
        do_cycle(0, 0, 0, 1, 1);
        do_cycle(1, 0, 1, 1, 1);
        samples(3, 0, 1);
        idle(BH + 2);

        // 5. Enable override from RECOVERING; samples ignored while disabled.
        samples(1, 0, 0);
        do_cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_cycle(1, 1, 1, 0, 0);
        idle(3);

        // Misconfigured limits (both set) and ack coinciding with a sample.
        samples(4, 1, 1);
        do_cycle(1, 0, 0, 1, 1);
        samples(3, 0, 0);
        idle(2);

        // 6. Saturation of the event counter.
        for (int k = 0; k < 256; k++) begin
            samples(4, k[0], !k[0]);
            samples(4, 0, 0);
        end
        idle(2);
        check("events_saturated", {6'd0, alarmEvents}, 14'd255);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            bit sv, bl, ah, en, ack;
            sv  = ($urandom_range(0, 99) < 60);
            bl  = ($urandom_range(0, 99) < 35);
            ah  = ($urandom_range(0, 99) < 35);
            en  = ($urandom_range(0, 99) >= 2);
            ack = ($urandom_range(0, 99) < 4);
            do_cycle(sv, bl, ah, en, ack);
        end
        idle(3);
        @(posedge clock);
        #2;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
